// File: rtl/force_seq_pkg.sv
// force_seq_pkg: shared state encoding and schedule-entry layout for the force sequencer.
package force_seq_pkg;
  localparam int SEQ_WIDTH = 8;
  localparam int SEQ_DEPTH = 8;
  localparam int SEQ_CYC_W = 32;

  typedef enum logic [1:0] {IDLE, WAIT, APPLY, DONE} state_t;

  typedef struct packed {
    logic [SEQ_CYC_W-1:0] start;
    logic [SEQ_CYC_W-1:0] stop;
    logic [SEQ_WIDTH-1:0] val;
    logic [SEQ_WIDTH-1:0] mask;
  } entry_t;
endpackage

// File: rtl/force_sched_table.sv
// force_sched_table: schedule register file, one write port and one combinational read port.
module force_sched_table
  import force_seq_pkg::*;
#(
  parameter int DEPTH = SEQ_DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  entry_t        wdata_i,
  input  logic [AW-1:0] raddr_i,
  output entry_t        rdata_o
);
  entry_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/force_schedule_seq.sv
// force_schedule_seq: replays a table of force/release windows keyed on a free-running cycle count.
module force_schedule_seq
  import force_seq_pkg::*;
#(
  parameter int WIDTH = SEQ_WIDTH,
  parameter int DEPTH = SEQ_DEPTH,
  parameter int CYC_W = SEQ_CYC_W,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CYC_W-1:0] cyc,
  input  logic             cfg_we,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [CYC_W-1:0] cfg_start,
  input  logic [CYC_W-1:0] cfg_end,
  input  logic [WIDTH-1:0] cfg_val,
  input  logic [WIDTH-1:0] cfg_mask,
  input  logic [AW:0]      cfg_num,
  input  logic             arm,
  input  logic             abort,
  output logic [WIDTH-1:0] force_en,
  output logic [WIDTH-1:0] force_val,
  output logic             active,
  output logic             done,
  output logic             err_late
);
  state_t          state_q;
  logic [AW-1:0]   idx_q;
  logic [AW:0]     num_q;
  logic            chk_q;
  logic            fin_q;
  logic [WIDTH-1:0] en_q;
  logic [WIDTH-1:0] val_q;
  logic            active_q;
  logic            done_q;
  logic            err_q;
  entry_t          wr;
  entry_t          cur;
  logic [AW:0]     num_d;
  logic [AW-1:0]   idx_d;
  logic            last;
  logic            bad;
  logic            hit;
  logic            at_end;

  assign wr = '{start: cfg_start, stop: cfg_end, val: cfg_val, mask: cfg_mask};

  force_sched_table #(.DEPTH(DEPTH)) u_table (
    .clk     (clk),
    .we_i    (cfg_we && state_q == IDLE),
    .waddr_i (cfg_addr),
    .wdata_i (wr),
    .raddr_i (idx_q),
    .rdata_o (cur)
  );

  assign num_d  = (cfg_num > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : cfg_num;
  assign last   = {1'b0, idx_q} == num_q - 1'b1;
  assign idx_d  = last ? idx_q : idx_q + 1'b1;
  assign bad    = (cur.stop < cur.start) || (cyc > cur.start);
  assign hit    = cyc == cur.start;
  assign at_end = cyc == cur.stop;

  // Advancing leaves the outputs untouched so the next WAIT edge either clears
  // them or, for a back-to-back window, loads the new mask with no gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      num_q    <= '0;
      chk_q    <= 1'b0;
      fin_q    <= 1'b0;
      en_q     <= '0;
      val_q    <= '0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else if (abort) begin
      state_q  <= IDLE;
      en_q     <= '0;
      val_q    <= '0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: if (arm) begin
          idx_q   <= '0;
          fin_q   <= 1'b0;
          chk_q   <= 1'b1;
          num_q   <= num_d;
          done_q  <= num_d == '0;
          state_q <= (num_d == '0) ? DONE : WAIT;
        end
        WAIT: begin
          if (fin_q) begin
            state_q  <= DONE;
            done_q   <= 1'b1;
            en_q     <= '0;
            val_q    <= '0;
            active_q <= 1'b0;
          end else if (chk_q && bad) begin
            err_q    <= 1'b1;
            idx_q    <= idx_d;
            fin_q    <= last;
            chk_q    <= 1'b1;
            en_q     <= '0;
            val_q    <= '0;
            active_q <= 1'b0;
          end else if (hit) begin
            en_q     <= cur.mask;
            val_q    <= cur.val & cur.mask;
            active_q <= 1'b1;
            idx_q    <= at_end ? idx_d : idx_q;
            fin_q    <= at_end && last;
            chk_q    <= at_end;
            state_q  <= at_end ? WAIT : APPLY;
          end else begin
            chk_q    <= 1'b0;
            en_q     <= '0;
            val_q    <= '0;
            active_q <= 1'b0;
          end
        end
        APPLY: if (at_end) begin
          idx_q   <= idx_d;
          fin_q   <= last;
          chk_q   <= 1'b1;
          state_q <= WAIT;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign force_en  = en_q;
  assign force_val = val_q;
  assign active    = active_q;
  assign done      = done_q;
  assign err_late  = err_q;
endmodule
